pipeline_hazard_controller: RTL and testbench
=============================================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameter LAT_W, default 3: width of the multi-cycle latency field and of the stall down-counter.
REQ-002 Parameter PERF_W, default 16: width of the stall-cycle performance counter.
REQ-003 Clk  input  1  the single clock; all state SHALL update on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset; Reset=0 SHALL force reset state immediately, with no clock edge required.
REQ-005 MemRead_EX  input  1  the instruction in EX is a load.
REQ-006 rt_address_EX  input  5  destination register of the EX load.
REQ-007 rs_address_ID, rt_address_ID  input  5 each  source registers of the ID instruction.
REQ-008 MultiCycle_ID  input  1  the ID instruction uses the multi-stage execute pipe (EX1..EX5).
REQ-009 MultiLat_ID  input  LAT_W  number of bubble cycles the ID multi-cycle instruction needs.
REQ-010 Jump_ID, JR_ID  input  1 each  the ID instruction is j/jal or jr.
REQ-011 BranchTaken_EX  input  1  the branch in EX resolved taken.
REQ-012 PCWrite  output  1  PC load enable.
REQ-013 IFIDWrite  output  1  IF/ID register load enable.
REQ-014 ControlMuxSig  output  1  1 = zero the ID control signals entering ID/EX (insert bubble).
REQ-015 IFIDFlush  output  1  1 = clear IF/ID on the next edge.
REQ-016 Busy  output  1  1 while the FSM is not in RUN.
REQ-017 StallCount  output  LAT_W  current multi-cycle down-counter value.
REQ-018 StallCycles  output  PERF_W  saturating count of cycles with PCWrite=0.

Function
REQ-019 The FSM SHALL have two states: RUN and MULTI. Outputs SHALL be decoded from state and current inputs in the same cycle (Mealy).
REQ-020 Load-use hazard: LU = MemRead_EX & (rt_address_EX != 0) & (rt_address_EX == rs_address_ID | rt_address_EX == rt_address_ID).
REQ-021 RUN, BranchTaken_EX=1: PCWrite=1, IFIDWrite=1, IFIDFlush=1, ControlMuxSig=1; stay in RUN. This case SHALL have highest priority.
REQ-022 RUN, LU=1, no branch: PCWrite=0, IFIDWrite=0, ControlMuxSig=1, IFIDFlush=0 for exactly that cycle; stay in RUN. No additional state is needed because the load leaves EX on the next edge.
REQ-023 RUN, MultiCycle_ID=1, MultiLat_ID=N>0, no LU, no branch: issue the instruction (ControlMuxSig=0, all enables 1); on the edge, go to MULTI and load the counter with N.
REQ-024 MultiLat_ID=0 SHALL be treated as a normal single-cycle issue; the FSM stays in RUN.
REQ-025 MULTI: PCWrite=0, IFIDWrite=0, ControlMuxSig=1; the counter decrements each edge; when the counter equals 1, the next state is RUN with the counter at 0. N bubble cycles are therefore produced.
REQ-026 MULTI, BranchTaken_EX=1 (older branch): abort. IFIDFlush=1, PCWrite=1, ControlMuxSig=1 that cycle; next state RUN; counter cleared to 0.
REQ-027 RUN, Jump_ID|JR_ID=1, no LU, no branch: IFIDFlush=1, PCWrite=1, IFIDWrite=1, ControlMuxSig=0. If LU also holds, LU wins and the jump is seen again on the next cycle.
REQ-028 Simultaneous LU and MultiCycle_ID SHALL produce the LU stall first; the multi-cycle issue follows on the next cycle.
REQ-029 StallCycles SHALL increment on each edge where PCWrite=0 and SHALL saturate at all-ones with no wrap.
REQ-030 Busy = (state == MULTI). StallCount SHALL always equal the internal counter.

Reset
REQ-031 While Reset=0: state=RUN, counter=0, StallCycles=0, PCWrite=0, IFIDWrite=0, ControlMuxSig=1, IFIDFlush=0, Busy=0.
REQ-032 Asserting reset mid-MULTI SHALL abandon the countdown. After release, the first edge behaves as RUN per REQ-021..028.

Verification
REQ-033 Load-use: MemRead_EX=1, rt_address_EX=5, rs_address_ID=5 -> one cycle of PCWrite=0, IFIDWrite=0, ControlMuxSig=1; StallCycles 0->1. With rt_address_EX=0 -> no stall.
REQ-034 Multi-cycle: MultiCycle_ID=1, MultiLat_ID=3 in RUN -> issue cycle, then exactly 3 MULTI cycles with StallCount 3,2,1 and Busy=1, then RUN; StallCycles +3.
REQ-035 Abort: BranchTaken_EX=1 during the 2nd cycle of a MultiLat_ID=4 stall -> IFIDFlush=1 and PCWrite=1 that cycle; next cycle RUN with StallCount=0.
REQ-036 Priority: LU, Jump_ID, and MultiCycle_ID all set in one cycle -> LU stall only; the next cycle (LU cleared) gives IFIDFlush=1.
REQ-037 Reset: Reset=0 mid-MULTI between edges -> outputs take REQ-031 values immediately; StallCycles=0. With PERF_W=4, 20 stall cycles -> StallCycles holds at 15.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: load-use stalls, multi-cycle execute bubbles,
// branch/jump flushes and a saturating stall-cycle performance counter.
// Handshake: PCWrite/IFIDWrite are load enables sampled on the rising edge;
// ControlMuxSig=1 injects a bubble into ID/EX, and IFIDFlush=1 clears IF/ID on
// the same edge. All outputs are Mealy-decoded from state and current inputs.
module pipeline_hazard_controller #(
   parameter int LAT_W  = 3,
   parameter int PERF_W = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              MemRead_EX,
   input  logic [4:0]        rt_address_EX,
   input  logic [4:0]        rs_address_ID,
   input  logic [4:0]        rt_address_ID,
   input  logic              MultiCycle_ID,
   input  logic [LAT_W-1:0]  MultiLat_ID,
   input  logic              Jump_ID,
   input  logic              JR_ID,
   input  logic              BranchTaken_EX,
   output logic              PCWrite,
   output logic              IFIDWrite,
   output logic              ControlMuxSig,
   output logic              IFIDFlush,
   output logic              Busy,
   output logic [LAT_W-1:0]  StallCount,
   output logic [PERF_W-1:0] StallCycles
);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_MULTI = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [LAT_W-1:0]    cnt_q, cnt_d;
   logic [PERF_W-1:0]   cyc_q, cyc_d;
   logic                load_use;

   // Load-use hazard: EX load writes a non-zero register read by ID.
   assign load_use = MemRead_EX && (rt_address_EX != 5'd0) &&
                     ((rt_address_EX == rs_address_ID) ||
                      (rt_address_EX == rt_address_ID));

   // Next-state and Mealy output decode; branch > load-use > jump/multi issue.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      PCWrite       = 1'b1;
      IFIDWrite     = 1'b1;
      ControlMuxSig = 1'b0;
      IFIDFlush     = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (BranchTaken_EX) begin
               ControlMuxSig = 1'b1;
               IFIDFlush     = 1'b1;
            end else if (load_use) begin
               // The load leaves EX next edge, so one bubble suffices.
               PCWrite       = 1'b0;
               IFIDWrite     = 1'b0;
               ControlMuxSig = 1'b1;
            end else begin
               IFIDFlush = Jump_ID || JR_ID;
               if (MultiCycle_ID && (MultiLat_ID != '0)) begin
                  state_d = ST_MULTI;
                  cnt_d   = MultiLat_ID;
               end
            end
         end
         ST_MULTI: begin
            ControlMuxSig = 1'b1;
            if (BranchTaken_EX) begin
               // An older branch resolved taken: abandon the countdown.
               IFIDFlush = 1'b1;
               state_d   = ST_RUN;
               cnt_d     = '0;
            end else begin
               PCWrite   = 1'b0;
               IFIDWrite = 1'b0;
               cnt_d     = cnt_q - LAT_W'(1);
               if (cnt_q <= LAT_W'(1)) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      endcase
      if (!Reset) begin
         PCWrite       = 1'b0;
         IFIDWrite     = 1'b0;
         ControlMuxSig = 1'b1;
         IFIDFlush     = 1'b0;
      end
   end

   // Saturating count of cycles in which the PC is held.
   always_comb begin
      cyc_d = cyc_q;
      if (!PCWrite && (cyc_q != {PERF_W{1'b1}})) begin
         cyc_d = cyc_q + PERF_W'(1);
      end
   end

   // State, down-counter and performance counter registers.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
         cyc_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cyc_q   <= cyc_d;
      end
   end

   assign Busy        = (state_q == ST_MULTI);
   assign StallCount  = cnt_q;
   assign StallCycles = cyc_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: a default instance and a PERF_W=4
// instance share stimulus; a cycle-level reference model predicts outputs.
module tb_pipeline_hazard_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       mem_read = 1'b0;
   logic [4:0] rt_ex = '0, rs_id = '0, rt_id = '0;
   logic       mc = 1'b0;
   logic [2:0] lat = '0;
   logic       jmp = 1'b0, jr = 1'b0, br = 1'b0;

   logic        pc_m, ifid_m, cms_m, fl_m, busy_m;
   logic [2:0]  cnt_m;
   logic [15:0] cyc_m;
   logic        pc_s, ifid_s, cms_s, fl_s, busy_s;
   logic [2:0]  cnt_s;
   logic [3:0]  cyc_s;

   logic [35:0] obs;
   logic [35:0] exp_q[$];
   logic [35:0] e;

   int total = 0;
   int bad = 0;

   // Reference model state: remaining bubble cycles and raw stall-cycle count.
   int   m_rem = 0;
   int   m_cyc = 0;
   logic m_pc = 1'b0;

   // Clock generation.
   always #5 clk = ~clk;

   pipeline_hazard_controller dut_main (
      .Clk(clk), .Reset(rst_n), .MemRead_EX(mem_read), .rt_address_EX(rt_ex),
      .rs_address_ID(rs_id), .rt_address_ID(rt_id), .MultiCycle_ID(mc),
      .MultiLat_ID(lat), .Jump_ID(jmp), .JR_ID(jr), .BranchTaken_EX(br),
      .PCWrite(pc_m), .IFIDWrite(ifid_m), .ControlMuxSig(cms_m),
      .IFIDFlush(fl_m), .Busy(busy_m), .StallCount(cnt_m), .StallCycles(cyc_m)
   );

   pipeline_hazard_controller #(.LAT_W(3), .PERF_W(4)) dut_small (
      .Clk(clk), .Reset(rst_n), .MemRead_EX(mem_read), .rt_address_EX(rt_ex),
      .rs_address_ID(rs_id), .rt_address_ID(rt_id), .MultiCycle_ID(mc),
      .MultiLat_ID(lat), .Jump_ID(jmp), .JR_ID(jr), .BranchTaken_EX(br),
      .PCWrite(pc_s), .IFIDWrite(ifid_s), .ControlMuxSig(cms_s),
      .IFIDFlush(fl_s), .Busy(busy_s), .StallCount(cnt_s), .StallCycles(cyc_s)
   );

   assign obs = {pc_m, ifid_m, cms_m, fl_m, busy_m, cnt_m, cyc_m,
                 pc_s, ifid_s, cms_s, fl_s, busy_s, cnt_s, cyc_s};

   function automatic logic is_lu();
      return mem_read && (rt_ex != 5'd0) && ((rt_ex == rs_id) || (rt_ex == rt_id));
   endfunction

   task automatic set_in(input logic a_mr, input logic [4:0] a_rtex,
                         input logic [4:0] a_rsid, input logic [4:0] a_rtid,
                         input logic a_mc, input logic [2:0] a_lat,
                         input logic a_j, input logic a_jr, input logic a_br);
      mem_read = a_mr; rt_ex = a_rtex; rs_id = a_rsid; rt_id = a_rtid;
      mc = a_mc; lat = a_lat; jmp = a_j; jr = a_jr; br = a_br;
   endtask

   // Predict the current-cycle outputs of both instances from the model.
   task automatic calc_exp();
      logic pc, ifid, cms, fl, busy;
      int c16, c4;
      if (!rst_n) begin
         m_rem = 0; m_cyc = 0;
         pc = 1'b0; ifid = 1'b0; cms = 1'b1; fl = 1'b0;
      end else if (m_rem > 0) begin
         pc = br; ifid = br; cms = 1'b1; fl = br;
      end else if (br) begin
         pc = 1'b1; ifid = 1'b1; cms = 1'b1; fl = 1'b1;
      end else if (is_lu()) begin
         pc = 1'b0; ifid = 1'b0; cms = 1'b1; fl = 1'b0;
      end else begin
         pc = 1'b1; ifid = 1'b1; cms = 1'b0; fl = jmp | jr;
      end
      busy = (m_rem > 0);
      c16 = (m_cyc > 65535) ? 65535 : m_cyc;
      c4  = (m_cyc > 15) ? 15 : m_cyc;
      m_pc = pc;
      exp_q.push_back({pc, ifid, cms, fl, busy, 3'(m_rem), 16'(c16),
                       pc, ifid, cms, fl, busy, 3'(m_rem), 4'(c4)});
   endtask

   // Wait to mid-cycle and record the prediction.
   task automatic settle();
      @(negedge clk);
      calc_exp();
   endtask

   // Clock edge: advance the model, then move just past the edge.
   task automatic advance();
      @(posedge clk);
      if (rst_n) begin
         if (!m_pc) m_cyc = m_cyc + 1;
         if (m_rem > 0) m_rem = br ? 0 : m_rem - 1;
         else if (!br && !is_lu() && mc && (lat != 3'd0)) m_rem = int'(lat);
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
      #2;
      calc_exp();
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
         bad++; $display("FAIL reset got=%h want=%h", obs, e);
      end
      advance();
      rst_n = 1'b1;
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_load_use();
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: set_in(1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
            1: set_in(1'b0, 5'd5, 5'd5, 5'd9, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
            2: set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
            default: set_in(1'b1, 5'd7, 5'd2, 5'd7, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
         endcase
         settle();
         e = exp_q.pop_front();
         total++;
         if (obs !== e) begin
            bad++; $display("FAIL load_use[%0d] got=%h want=%h", i, obs, e);
         end
         advance();
      end
   endtask

   task automatic test_multi();
      for (int i = 0; i < 6; i++) begin
         if (i == 0) set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
         else        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
         settle();
         e = exp_q.pop_front();
         total++;
         if (obs !== e) begin
            bad++; $display("FAIL multi[%0d] got=%h want=%h", i, obs, e);
         end
         advance();
      end
   endtask

   task automatic test_abort();
      for (int i = 0; i < 5; i++) begin
         if (i == 0)      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
         else if (i == 2) set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
         else             set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
         settle();
         e = exp_q.pop_front();
         total++;
         if (obs !== e) begin
            bad++; $display("FAIL abort[%0d] got=%h want=%h", i, obs, e);
         end
         advance();
      end
   endtask

   task automatic test_priority();
      for (int i = 0; i < 4; i++) begin
         if (i == 0) set_in(1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
         else if (i == 1) set_in(1'b0, 5'd3, 5'd3, 5'd0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
         else set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
         settle();
         e = exp_q.pop_front();
         total++;
         if (obs !== e) begin
            bad++; $display("FAIL priority[%0d] got=%h want=%h", i, obs, e);
         end
         advance();
      end
   endtask

   task automatic test_reset_mid_multi();
      for (int i = 0; i < 3; i++) begin
         if (i == 0) set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
         else        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
         settle();
         e = exp_q.pop_front();
         total++;
         if (obs !== e) begin
            bad++; $display("FAIL mid_pre[%0d] got=%h want=%h", i, obs, e);
         end
         advance();
      end
      #2;
      rst_n = 1'b0;
      #1;
      calc_exp();
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
         bad++; $display("FAIL mid_reset got=%h want=%h", obs, e);
      end
      advance();
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         settle();
         e = exp_q.pop_front();
         total++;
         if (obs !== e) begin
            bad++; $display("FAIL mid_post[%0d] got=%h want=%h", i, obs, e);
         end
         advance();
      end
   endtask

   task automatic test_saturation();
      set_in(1'b1, 5'd6, 5'd6, 5'd6, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         settle();
         e = exp_q.pop_front();
         total++;
         if (obs !== e) begin
            bad++; $display("FAIL saturate[%0d] got=%h want=%h", i, obs, e);
         end
         advance();
      end
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      #2;
      total++;
      if (cyc_s !== 4'd15) begin
         bad++; $display("FAIL saturate_hold got=%0d want=15", cyc_s);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         set_in($urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
                $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 9) == 0);
         settle();
         e = exp_q.pop_front();
         total++;
         if (obs !== e) begin
            bad++; $display("FAIL random[%0d] got=%h want=%h", i, obs, e);
         end
         advance();
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_multi();
      test_abort();
      test_priority();
      test_reset_mid_multi();
      test_saturation();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
